// File: rtl/imem_program_loader_pkg.sv
// -----------------------------------------------------------------------------
// loader_pkg
// Shared definitions for imem_program_loader and its checksum helper:
//   - loader_state_e : sequencer states
//   - header field positions (payload length in the upper half, base address
//     in the low ADRS_W bits)
//   - LEN_W          : width of the payload length field
// -----------------------------------------------------------------------------
package loader_pkg;

    typedef enum logic [2:0] {
        ST_HDR   = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHK   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_RUN   = 3'd4,
        ST_ERR   = 3'd5
    } loader_state_e;

    localparam int LEN_W    = 16;
    localparam int LEN_LSB  = 16;
    localparam int LEN_MSB  = LEN_LSB + LEN_W - 1;
    localparam int BASE_LSB = 0;

    // States in which the loader still owns the memory write port.
    function automatic logic state_is_busy(input loader_state_e st);
        return (st == ST_HDR) || (st == ST_LOAD) || (st == ST_CHK) || (st == ST_DRAIN);
    endfunction

endpackage

// File: rtl/imem_program_loader_if.sv
// -----------------------------------------------------------------------------
// imem_program_loader_if
// Word stream into the program loader (valid/ready handshake).
//   s_valid : word valid        (master -> slave)
//   s_data  : stream word       (master -> slave)
//   s_ready : word accepted when s_valid && s_ready (slave -> master)
// Modports: master (host link side), slave (loader side).
// -----------------------------------------------------------------------------
interface imem_program_loader_if #(
    parameter int DATA_SIZE = 32
) ();

    logic                 s_valid;
    logic [DATA_SIZE-1:0] s_data;
    logic                 s_ready;

    modport master (
        output s_valid,
        output s_data,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready
    );

endinterface

// File: rtl/imem_program_loader_checksum.sv
// -----------------------------------------------------------------------------
// loader_checksum
// Running DATA_SIZE-bit wrap-around sum of payload words, with a compare
// against the checksum word presented on cmp_data.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : restart the sum at zero (takes priority over acc_en)
//   acc_en     : add data into the running sum
//   data       : payload word to accumulate
//   cmp_data   : checksum word to compare
//   match      : cmp_data equals the running sum (combinational)
// -----------------------------------------------------------------------------
module loader_checksum #(
    parameter int DATA_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 acc_en,
    input  logic [DATA_SIZE-1:0] data,
    input  logic [DATA_SIZE-1:0] cmp_data,
    output logic                 match
);

    logic [DATA_SIZE-1:0] sum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else if (clear) begin
            sum_q <= '0;
        end else if (acc_en) begin
            sum_q <= sum_q + data;
        end
    end

    assign match = (cmp_data == sum_q);

endmodule

// File: rtl/imem_program_loader.sv
// -----------------------------------------------------------------------------
// imem_program_loader
// Boot/reload sequencer for the multicore CPU memory write port. Takes a
// framed word stream (header, payload[, checksum]) and turns each payload word
// into a registered memory write one cycle after it is accepted. cpu_en is
// held low while programming and rises once the load and the drain delay are
// complete.
//
// Header word: len = s_data[31:16] (payload words), base = s_data[ADRS_W-1:0].
//
// Optional feature: define LOADER_CHECKSUM_EN to require one checksum word
// (wrap-around sum of the payload) after the payload; a mismatch goes to ERR.
//
// Ports:
//   sys_clk        system clock, rising edge
//   resetn         asynchronous active-low reset
//   s (slave)      word stream: s_valid, s_data, s_ready
//   reload         1-cycle pulse: drop cpu_en and wait for a new header
//   w_enable       memory write strobe (registered)
//   w_adrs         memory write address (registered)
//   w_instruction  memory write data (registered)
//   cpu_en         core run enable (registered)
//   busy           high in HDR/LOAD/CHK/DRAIN
//   error          high in ERR, cleared by reload
// -----------------------------------------------------------------------------
module imem_program_loader
    import loader_pkg::*;
#(
    parameter int DATA_SIZE    = 32,
    parameter int ADRS_W       = 11,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic                  sys_clk,
    input  logic                  resetn,
    imem_program_loader_if.slave  s,
    input  logic                  reload,
    output logic                  w_enable,
    output logic [ADRS_W-1:0]     w_adrs,
    output logic [DATA_SIZE-1:0]  w_instruction,
    output logic                  cpu_en,
    output logic                  busy,
    output logic                  error
);

    localparam longint unsigned DEPTH   = 64'd1 << ADRS_W;
    localparam int              DRAIN_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

    loader_state_e      state_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   cnt_q;
    logic [ADRS_W-1:0]  addr_q;
    logic [DRAIN_W-1:0] drain_q;

    logic               ready;
    logic               accept;
    logic [LEN_W-1:0]   hdr_len;
    logic [ADRS_W-1:0]  hdr_base;
    logic               hdr_oversize;
    logic               last_word;

    assign ready  = ((state_q == ST_HDR) || (state_q == ST_LOAD) || (state_q == ST_CHK)) && !reload;
    assign accept = s.s_valid && ready;

    assign s.s_ready = ready;
    assign busy      = state_is_busy(state_q);

    assign hdr_len      = s.s_data[LEN_MSB:LEN_LSB];
    assign hdr_base     = s.s_data[BASE_LSB +: ADRS_W];
    // A full-depth image (len == DEPTH) is legal; anything longer would overwrite itself.
    assign hdr_oversize = 64'(hdr_len) > DEPTH;
    assign last_word    = (cnt_q == (len_q - LEN_W'(1)));

`ifdef LOADER_CHECKSUM_EN
    logic sum_clear;
    logic sum_acc;
    logic sum_match;

    assign sum_clear = reload || ((state_q == ST_HDR) && accept);
    assign sum_acc   = (state_q == ST_LOAD) && accept;

    loader_checksum #(
        .DATA_SIZE (DATA_SIZE)
    ) u_checksum (
        .clk      (sys_clk),
        .rst_n    (resetn),
        .clear    (sum_clear),
        .acc_en   (sum_acc),
        .data     (s.s_data),
        .cmp_data (s.s_data),
        .match    (sum_match)
    );
`endif

    always_ff @(posedge sys_clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_HDR;
            len_q         <= '0;
            cnt_q         <= '0;
            addr_q        <= '0;
            drain_q       <= '0;
            w_enable      <= 1'b0;
            w_adrs        <= '0;
            w_instruction <= '0;
            cpu_en        <= 1'b0;
            error         <= 1'b0;
        end else begin
            // A write strobe only ever lasts the cycle after its accept.
            w_enable <= 1'b0;

            if (reload) begin
                state_q <= ST_HDR;
                cnt_q   <= '0;
                drain_q <= '0;
                cpu_en  <= 1'b0;
                error   <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_HDR: begin
                        if (accept) begin
                            len_q   <= hdr_len;
                            addr_q  <= hdr_base;
                            cnt_q   <= '0;
                            drain_q <= '0;
                            if (hdr_oversize) begin
                                state_q <= ST_ERR;
                                error   <= 1'b1;
                            end else if (hdr_len == '0) begin
`ifdef LOADER_CHECKSUM_EN
                                state_q <= ST_CHK;
`else
                                state_q <= ST_DRAIN;
`endif
                            end else begin
                                state_q <= ST_LOAD;
                            end
                        end
                    end

                    ST_LOAD: begin
                        if (accept) begin
                            w_enable      <= 1'b1;
                            w_adrs        <= addr_q;
                            w_instruction <= s.s_data;
                            // Address wraps naturally at the ADRS_W boundary.
                            addr_q        <= addr_q + ADRS_W'(1);
                            cnt_q         <= cnt_q + LEN_W'(1);
                            if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                                state_q <= ST_CHK;
`else
                                state_q <= ST_DRAIN;
`endif
                            end
                        end
                    end

`ifdef LOADER_CHECKSUM_EN
                    ST_CHK: begin
                        if (accept) begin
                            if (sum_match) begin
                                state_q <= ST_DRAIN;
                            end else begin
                                state_q <= ST_ERR;
                                error   <= 1'b1;
                            end
                        end
                    end
`endif

                    // The DRAIN entry cycle is the last write cycle itself, so
                    // RUN follows DRAIN_CYCLES further idle cycles.
                    ST_DRAIN: begin
                        if (drain_q == DRAIN_W'(DRAIN_CYCLES)) begin
                            state_q <= ST_RUN;
                            cpu_en  <= 1'b1;
                        end else begin
                            drain_q <= drain_q + DRAIN_W'(1);
                        end
                    end

                    ST_RUN: begin
                        cpu_en <= 1'b1;
                    end

                    ST_ERR: begin
                        cpu_en <= 1'b0;
                        error  <= 1'b1;
                    end

                    default: begin
                        state_q <= ST_HDR;
                    end
                endcase
            end
        end
    end

endmodule
